// File: rtl/adc_ctrl_if.sv
// Serial-audio ADC link: clock outputs, serial data in, parallel stereo samples out.
// The controller side is the master (it drives every clock), the consumer/ADC side is the slave.
`timescale 1ns/1ps
interface adc_ctrl_if;
  logic        mclk;
  logic        sclk;
  logic        lrck;
  logic        sdto;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        valid;

  modport master (
    output mclk, sclk, lrck, sample_l, sample_r, valid,
    input  sdto
  );

  modport slave (
    input  mclk, sclk, lrck, sample_l, sample_r, valid,
    output sdto
  );
endinterface

// File: rtl/adc_ctrl.sv
// I2S 16-bit stereo receiver; clocks derived from a free-running 1024-cycle frame counter.
// Pair strobed on cnt==780 (<=5 clk after right LSB sclk rise); no backpressure, samples held 1024 cycles.
`timescale 1ns/1ps
module adc_ctrl (
  input  logic       clk,
  input  logic       reset,
  adc_ctrl_if.master bus
);

  localparam logic [3:0] CAP_PHASE  = 4'hB;
  localparam logic [9:0] LEFT_HOLD  = 10'd268;
  localparam logic [9:0] RIGHT_DONE = 10'd779;

  logic [9:0]  cnt_q, cnt_d;
  logic        s1_q, s2_q;
  logic [15:0] shl_q, shl_d;
  logic [15:0] shr_q, shr_d;
  logic [15:0] left_hold_q, left_hold_d;
  logic [15:0] sample_l_q, sample_l_d;
  logic [15:0] sample_r_q, sample_r_d;
  logic        valid_q, valid_d;

  logic [4:0]  slot;
  logic        right_half;
  logic        cap_en;

  assign slot       = cnt_q[8:4];
  assign right_half = cnt_q[9];
  // Slot 0 is the I2S one-bit delay; slots 17..31 are padding after the LSB.
  assign cap_en     = (cnt_q[3:0] == CAP_PHASE) && (slot >= 5'd1) && (slot <= 5'd16);

  always_comb begin
    cnt_d       = cnt_q + 10'd1;
    shl_d       = shl_q;
    shr_d       = shr_q;
    left_hold_d = left_hold_q;
    sample_l_d  = sample_l_q;
    sample_r_d  = sample_r_q;
    valid_d     = 1'b0;

    if (slot == 5'd0) begin
      if (right_half) shr_d = '0;
      else            shl_d = '0;
    end else if (cap_en) begin
      if (right_half) shr_d = {shr_q[14:0], s2_q};
      else            shl_d = {shl_q[14:0], s2_q};
    end

    if (cnt_q == LEFT_HOLD) left_hold_d = shl_q;

    // shr_d already contains the LSB captured on this same edge.
    if (cnt_q == RIGHT_DONE) begin
      sample_l_d = left_hold_q;
      sample_r_d = shr_d;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      shl_q       <= '0;
      shr_q       <= '0;
      left_hold_q <= '0;
      sample_l_q  <= '0;
      sample_r_q  <= '0;
      valid_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      s1_q        <= bus.sdto;
      s2_q        <= s1_q;
      shl_q       <= shl_d;
      shr_q       <= shr_d;
      left_hold_q <= left_hold_d;
      sample_l_q  <= sample_l_d;
      sample_r_q  <= sample_r_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.mclk     = cnt_q[1];
  assign bus.sclk     = cnt_q[3];
  assign bus.lrck     = cnt_q[9];
  assign bus.sample_l = sample_l_q;
  assign bus.sample_r = sample_r_q;
  assign bus.valid    = valid_q;

endmodule

// File: tb/tb_adc_ctrl.sv
// Bench for adc_ctrl: jittered I2S ADC model plus a per-cycle reference derived from frame arithmetic.
`timescale 1ns/1ps
module tb_adc_ctrl;

  logic clk;
  logic reset;
  adc_ctrl_if bus ();

  adc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Words sent in each frame of the current segment, indexed by frame number since reset release.
  logic [15:0] wl [0:31];
  logic [15:0] wr [0:31];
  bit          fill_ones = 1'b0;
  int          seg_id    = 0;
  bit          mon_en    = 1'b0;

  // Edges since reset release; the design's frame position is k mod 1024.
  int k;
  always @(posedge clk or negedge reset) begin
    if (!reset) k <= 0;
    else        k <= k + 1;
  end

  // ADC model: changes sdto a jittered delay after each sclk fall, tracking slots from lrck itself.
  int adc_seg   = -1;
  int adc_slot  = 0;
  int adc_frame = 0;
  bit adc_prev  = 1'b0;
  initial bus.sdto = 1'b0;

  always @(negedge bus.sclk) begin : adc_model
    int unsigned d;
    logic [15:0] w;
    d = $urandom_range(2, 8);
    #(d);
    if (reset) begin
      if (adc_seg != seg_id) begin
        adc_seg   = seg_id;
        adc_slot  = 0;
        adc_frame = 0;
        adc_prev  = 1'b0;
      end
      if (bus.lrck != adc_prev) begin
        adc_slot = 0;
        if (!bus.lrck) adc_frame++;
        adc_prev = bus.lrck;
      end else begin
        adc_slot++;
      end
      w = bus.lrck ? wr[adc_frame] : wl[adc_frame];
      if (adc_slot >= 1 && adc_slot <= 16) bus.sdto = w[16 - adc_slot];
      else                                 bus.sdto = fill_ones ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Reference: clocks are counter bits; pair from frame f appears at f*1024+780 and is held.
  always @(negedge clk) begin : monitor
    int c;
    int f;
    logic [15:0] el, er;
    if (reset && mon_en) begin
      c = k % 1024;
      chk("mclk", 32'(bus.mclk), 32'((c / 2) % 2));
      chk("sclk", 32'(bus.sclk), 32'((c / 8) % 2));
      chk("lrck", 32'(bus.lrck), 32'((c / 512) % 2));
      chk("valid", 32'(bus.valid), 32'(c == 780));
      el = '0;
      er = '0;
      if (k >= 780) begin
        f  = (k - 780) / 1024;
        el = wl[f];
        er = wr[f];
      end
      chk("sample_l", 32'(bus.sample_l), 32'(el));
      chk("sample_r", 32'(bus.sample_r), 32'(er));
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_mclk"},  32'(bus.mclk), 32'd0);
    chk({tag, "_sclk"},  32'(bus.sclk), 32'd0);
    chk({tag, "_lrck"},  32'(bus.lrck), 32'd0);
    chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
    chk({tag, "_sl"},    32'(bus.sample_l), 32'd0);
    chk({tag, "_sr"},    32'(bus.sample_r), 32'd0);
  endtask

  // Assert reset between clock edges and confirm outputs clear without waiting for a clock.
  task automatic hit_reset(input string tag);
    @(posedge clk);
    #7;
    reset = 1'b0;
    #1;
    check_all_zero(tag);
    seg_id++;
    repeat (3) @(posedge clk);
  endtask

  task automatic release_and_run(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      wl[i] = '0;
      wr[i] = '0;
    end
    #35;
    check_all_zero("por");
    mon_en = 1'b1;

    // Basic capture, 3 frames
    for (int i = 0; i < 32; i++) begin
      wl[i] = 16'h0FF0;
      wr[i] = 16'hAA55;
    end
    seg_id++;
    release_and_run(3 * 1024);

    // Extremes, alternating pairs
    hit_reset("rst_a");
    for (int i = 0; i < 32; i++) begin
      wl[i] = (i % 2 == 0) ? 16'h8000 : 16'h0001;
      wr[i] = (i % 2 == 0) ? 16'h7FFF : 16'hFFFF;
    end
    release_and_run(4 * 1024);

    // Framing guard: ones in every ignored slot, zero words
    hit_reset("rst_b");
    fill_ones = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wl[i] = 16'h0000;
      wr[i] = 16'h0000;
    end
    release_and_run(2 * 1024);
    fill_ones = 1'b0;

    // Mid-frame reset after left_hold was loaded
    hit_reset("rst_c");
    for (int i = 0; i < 32; i++) begin
      wl[i] = 16'($urandom);
      wr[i] = 16'($urandom);
    end
    release_and_run(400);
    hit_reset("rst_mid");

    // 20 random frames with jittered sdto
    for (int i = 0; i < 32; i++) begin
      wl[i] = 16'($urandom);
      wr[i] = 16'($urandom);
    end
    release_and_run(20 * 1024);

    @(negedge clk);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
